// File: rtl/ram_sdp_be_pkg.sv
// rtl/ram_sdp_be_pkg.sv - shared constants and types for the byte-enable simple-dual-port RAM
package ram_sdp_be_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/ram_sdp_be_if.sv
// rtl/ram_sdp_be_if.sv - write/read port bundle for ram_sdp_be
interface ram_sdp_be_if #(
    parameter int AWID = 8,
    parameter int DWID = 16,
    parameter int BWID = 8
) ();
    localparam int NLANE = DWID / BWID;

    logic             i_we;
    logic [NLANE-1:0] i_be;
    logic [AWID-1:0]  i_waddr;
    logic [DWID-1:0]  i_wdat;
    logic             i_re;
    logic [AWID-1:0]  i_raddr;
    logic [DWID-1:0]  o_rdat;
    logic             o_rvalid;
    logic             o_busy;

    modport master (
        output i_we, i_be, i_waddr, i_wdat, i_re, i_raddr,
        input  o_rdat, o_rvalid, o_busy
    );

    modport slave (
        input  i_we, i_be, i_waddr, i_wdat, i_re, i_raddr,
        output o_rdat, o_rvalid, o_busy
    );

endinterface

// File: rtl/ram_sdp_be_rd_pipe.sv
// rtl/ram_sdp_be_rd_pipe.sv - RD_LAT-deep read valid/data delay line with synchronous flush
module ram_sdp_be_rd_pipe #(
    parameter int DWID   = 16,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [DWID-1:0] in_dat,
    output logic            out_valid,
    output logic [DWID-1:0] out_dat
);

    logic [RD_LAT-1:0]           vld;
    logic [RD_LAT-1:0][DWID-1:0] dat;

    // Data stages load only behind a valid, so the output word holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            dat <= '0;
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_dat;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_valid = vld[RD_LAT-1];
    assign out_dat   = dat[RD_LAT-1];

endmodule

// File: rtl/ram_sdp_be.sv
// rtl/ram_sdp_be.sv - simple-dual-port RAM with byte-lane writes, 1/2-cycle reads and post-reset clear
module ram_sdp_be
    import ram_sdp_be_pkg::*;
#(
    parameter int AWID     = 8,
    parameter int DWID     = 16,
    parameter int BWID     = 8,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0,
    parameter int CLR_EN   = 1
) (
    input  logic         clk,
    input  logic         rst,
    ram_sdp_be_if.slave  bus
);

    localparam int DEPTH = 2 ** AWID;
    localparam int NLANE = DWID / BWID;

    if ((DWID % BWID) != 0) begin : g_bad_bwid
        $error("ram_sdp_be: DWID must be a multiple of BWID");
    end
    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_lat
        $error("ram_sdp_be: RD_LAT must be 1 or 2");
    end

    state_t          state;
    state_t          state_nxt;
    logic [AWID-1:0] cnt;
    logic [AWID-1:0] cnt_nxt;
    logic            busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLR_EN != 0) ? ST_CLEAR : ST_READY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_CLEAR: begin
                cnt_nxt = cnt + AWID'(1);
                if (cnt == AWID'(DEPTH - 1)) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_READY;
        endcase
    end

    // Reset itself counts as busy so no user access slips in before the clear starts.
    assign busy = rst ? (CLR_EN != 0) : (state == ST_CLEAR);

    logic             user_we;
    logic [NLANE-1:0] wr_be;
    logic [AWID-1:0]  wr_addr;
    logic [DWID-1:0]  wr_dat;

    assign user_we = bus.i_we && !busy;

    always_comb begin
        wr_be   = '0;
        wr_addr = bus.i_waddr;
        wr_dat  = bus.i_wdat;
        if (!rst) begin
            if (state == ST_CLEAR) begin
                wr_be   = '1;
                wr_addr = cnt;
                wr_dat  = '0;
            end else if (user_we) begin
                wr_be = bus.i_be;
            end
        end
    end

    logic [DWID-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        for (int k = 0; k < NLANE; k++) begin
            if (wr_be[k]) begin
                mem[wr_addr][k*BWID +: BWID] <= wr_dat[k*BWID +: BWID];
            end
        end
    end

    logic            rd_acc;
    logic [DWID-1:0] rd_old;
    logic [DWID-1:0] rd_word;

    assign rd_acc = bus.i_re && !busy;
    assign rd_old = mem[bus.i_raddr];

    // New-data mode forwards only the lanes being written this cycle.
    always_comb begin
        rd_word = rd_old;
        if ((RDW_MODE == RDW_NEW) && user_we && (bus.i_waddr == bus.i_raddr)) begin
            for (int k = 0; k < NLANE; k++) begin
                if (bus.i_be[k]) begin
                    rd_word[k*BWID +: BWID] = bus.i_wdat[k*BWID +: BWID];
                end
            end
        end
    end

    ram_sdp_be_rd_pipe #(
        .DWID   (DWID),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_acc),
        .in_dat    (rd_word),
        .out_valid (bus.o_rvalid),
        .out_dat   (bus.o_rdat)
    );

    assign bus.o_busy = busy;

endmodule

// File: tb/tb_ram_sdp_be.sv
// tb/tb_ram_sdp_be.sv - self-checking bench for ram_sdp_be over all RD_LAT/RDW_MODE combinations
module tb_ram_sdp_be;

    localparam int NCFG = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        we;
    logic        re;
    logic [1:0]  be;
    logic [7:0]  waddr;
    logic [7:0]  raddr;
    logic [15:0] wdat;

    logic [NCFG-1:0]       rv_o;
    logic [NCFG-1:0]       busy_o;
    logic [NCFG-1:0][15:0] rdat_o;

    // cfg c: RD_LAT = c%2+1, RDW_MODE = c/2; all instances see identical stimulus
    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        ram_sdp_be_if #(.AWID(8), .DWID(16), .BWID(8)) bus ();
        assign bus.i_we    = we;
        assign bus.i_be    = be;
        assign bus.i_waddr = waddr;
        assign bus.i_wdat  = wdat;
        assign bus.i_re    = re;
        assign bus.i_raddr = raddr;
        assign rv_o[g]     = bus.o_rvalid;
        assign rdat_o[g]   = bus.o_rdat;
        assign busy_o[g]   = bus.o_busy;

        ram_sdp_be #(
            .AWID(8), .DWID(16), .BWID(8),
            .RD_LAT((g % 2) + 1), .RDW_MODE(g / 2), .CLR_EN(1)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    typedef struct {
        logic        v;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        chk;
        logic [15:0] e0;
        logic [15:0] e1;
    } rd_rec_t;

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [7:0]  waddr;
        logic [15:0] wdat;
        logic        re;
        logic [7:0]  raddr;
        logic        chk;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    logic [15:0] mem_m [256];
    int          clr_left;
    rd_rec_t     cur;
    rd_rec_t     prev;
    rd_rec_t     m_rec;
    rd_rec_t     m_e;
    logic [15:0] exp_last [NCFG];
    logic        m_busy;
    bit          started;
    int          busy_run;
    logic        t_chk;
    logic [15:0] t_e0;
    logic [15:0] t_e1;
    vec_t        vt [10];

    int checks;
    int errors;

    task automatic chk(input string name, input int c, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d t=%0t: got %h expected %h", name, c, $time, act, exp);
        end
    endtask

    // Memory as a plain array; a read captures both the pre-write word and the lane-merged word.
    task automatic model_update();
        m_busy   = rst || (clr_left > 0);
        m_rec.v  = re && !m_busy;
        m_rec.d0 = mem_m[raddr];
        m_rec.d1 = m_rec.d0;
        m_rec.chk = t_chk;
        m_rec.e0 = t_e0;
        m_rec.e1 = t_e1;
        if (we && !m_busy) begin
            for (int k = 0; k < 2; k++) begin
                if (be[k]) begin
                    if (waddr == raddr) m_rec.d1[k*8 +: 8] = wdat[k*8 +: 8];
                    mem_m[waddr][k*8 +: 8] = wdat[k*8 +: 8];
                end
            end
        end
        prev = cur;
        cur  = m_rec;
        if (rst) begin
            clr_left = 256;
            for (int a = 0; a < 256; a++) mem_m[a] = 16'h0000;
            cur.v  = 1'b0;
            prev.v = 1'b0;
            for (int c = 0; c < NCFG; c++) exp_last[c] = 16'h0000;
            started = 1'b1;
        end else if (clr_left > 0) begin
            clr_left--;
        end
    endtask

    task automatic compare();
        if (!started) return;
        for (int c = 0; c < NCFG; c++) begin
            m_e = ((c % 2) == 0) ? cur : prev;
            if (m_e.v) exp_last[c] = ((c / 2) == 1) ? m_e.d1 : m_e.d0;
            chk("rvalid", c, 16'(rv_o[c]), 16'(m_e.v));
            chk("rdat", c, rdat_o[c], exp_last[c]);
            chk("busy", c, 16'(busy_o[c]), 16'(rst || (clr_left > 0)));
            if (m_e.v && m_e.chk) chk("rdat_vec", c, rdat_o[c], ((c / 2) == 1) ? m_e.e1 : m_e.e0);
        end
        if (rst) begin
            busy_run = busy_o[0] ? 1 : 0;
        end else if (busy_o[0]) begin
            busy_run++;
        end else if (busy_run > 0) begin
            chk("busy_len", 0, 16'(busy_run), 16'd256);
            busy_run = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; be = 2'b00; t_chk = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (busy_o[0] && n < 400) begin
            tick();
            n++;
        end
        chk("ready_wait", 0, 16'(n < 400), 16'd1);
    endtask

    function automatic vec_t mk(logic w, logic [1:0] b, logic [7:0] wa, logic [15:0] wd,
                                logic r, logic [7:0] ra, logic c, logic [15:0] x0, logic [15:0] x1);
        vec_t v;
        v.we = w; v.be = b; v.waddr = wa; v.wdat = wd;
        v.re = r; v.raddr = ra; v.chk = c; v.e0 = x0; v.e1 = x1;
        return v;
    endfunction

    initial begin
        checks = 0; errors = 0; started = 1'b0; busy_run = 0; clr_left = 0;
        cur = '{default: '0}; prev = '{default: '0};
        waddr = 8'h00; raddr = 8'h00; wdat = 16'h0000; t_e0 = 16'h0; t_e1 = 16'h0;
        idle();

        vt[0] = mk(1, 2'b11, 8'h10, 16'hAAAA, 0, 8'h00, 0, 16'h0000, 16'h0000);
        vt[1] = mk(1, 2'b01, 8'h10, 16'h1234, 0, 8'h00, 0, 16'h0000, 16'h0000);
        vt[2] = mk(0, 2'b00, 8'h00, 16'h0000, 1, 8'h10, 1, 16'hAA34, 16'hAA34);
        vt[3] = mk(1, 2'b11, 8'h20, 16'h5555, 0, 8'h00, 0, 16'h0000, 16'h0000);
        vt[4] = mk(1, 2'b10, 8'h20, 16'hBEEF, 1, 8'h20, 1, 16'h5555, 16'hBE55);
        vt[5] = mk(0, 2'b00, 8'h00, 16'h0000, 1, 8'h20, 1, 16'hBE55, 16'hBE55);
        vt[6] = mk(1, 2'b00, 8'h30, 16'hFFFF, 0, 8'h00, 0, 16'h0000, 16'h0000);
        vt[7] = mk(0, 2'b00, 8'h00, 16'h0000, 1, 8'h30, 1, 16'h0030, 16'h0030);
        vt[8] = mk(1, 2'b11, 8'h40, 16'hCAFE, 1, 8'h41, 1, 16'h0041, 16'h0041);
        vt[9] = mk(0, 2'b00, 8'h00, 16'h0000, 1, 8'h40, 1, 16'hCAFE, 16'hCAFE);

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // accesses while the clear runs must be dropped
        for (int i = 0; i < 10; i++) tick();
        we = 1'b1; be = 2'b11; waddr = 8'h05; wdat = 16'hFFFF; re = 1'b1; raddr = 8'h05;
        tick();
        idle();
        wait_ready();

        for (int a = 0; a < 256; a++) begin
            re = 1'b1; raddr = 8'(a); t_chk = 1'b1; t_e0 = 16'h0000; t_e1 = 16'h0000;
            tick();
        end
        idle();
        tick(); tick();

        for (int a = 0; a < 256; a++) begin
            we = 1'b1; be = 2'b11; waddr = 8'(a); wdat = 16'(a);
            tick();
        end
        idle();
        for (int a = 0; a < 256; a++) begin
            re = 1'b1; raddr = 8'(a); t_chk = 1'b1; t_e0 = 16'(a); t_e1 = 16'(a);
            tick();
        end
        idle();
        tick(); tick();

        for (int i = 0; i < 10; i++) begin
            we = vt[i].we; be = vt[i].be; waddr = vt[i].waddr; wdat = vt[i].wdat;
            re = vt[i].re; raddr = vt[i].raddr; t_chk = vt[i].chk; t_e0 = vt[i].e0; t_e1 = vt[i].e1;
            tick();
        end
        idle();
        tick(); tick();

        // narrow address range forces frequent same-address collisions
        for (int i = 0; i < 1500; i++) begin
            we = 1'($urandom); re = 1'($urandom); be = 2'($urandom);
            waddr = 8'($urandom_range(0, 15)); raddr = 8'($urandom_range(0, 15));
            wdat = 16'($urandom);
            tick();
        end
        idle();
        tick(); tick();

        // reset lands one cycle before the RD_LAT=2 result would appear
        re = 1'b1; raddr = 8'h03;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready();

        // read and reset in the same cycle
        tick();
        re = 1'b1; raddr = 8'h07; rst = 1'b1;
        tick();
        idle();
        rst = 1'b0;
        wait_ready();
        for (int i = 0; i < 20; i++) begin
            re = 1'b1; raddr = 8'($urandom_range(0, 255)); t_chk = 1'b1; t_e0 = 16'h0; t_e1 = 16'h0;
            tick();
        end
        idle();
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
